req_arbiter_4_v: RTL and testbench

- Sequential 4-requester arbiter for one shared resource (bus, datapath port, memory bank).
- Registers requests and selects a winner with a 4:2 priority encode (line 0 highest), then holds a one-hot grant.
- Enforces a bounded grant tenure so no requester can hold the resource forever.
- Sits between requesting blocks and the shared resource's select mux.

---
 rtl/req_arbiter_pkg.sv | 19 +
 rtl/priority_enc_4_2_v.sv | 19 +
 rtl/req_arbiter_4_v.sv | 145 ++++++++++++++
 tb/tb_req_arbiter_4_v.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/req_arbiter_pkg.sv
// Shared types and helpers for the 4-requester arbiter slice.
package req_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot_from_idx(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/priority_enc_4_2_v.sv
// Combinational 4:2 priority encoder; bit 0 has highest priority.
module priority_enc_4_2_v
  import req_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = |i_req;
    if (i_req[0])      o_idx = 2'd0;
    else if (i_req[1]) o_idx = 2'd1;
    else if (i_req[2]) o_idx = 2'd2;
    else if (i_req[3]) o_idx = 2'd3;
  end

endmodule

// File: rtl/req_arbiter_4_v.sv
// 4-requester arbiter with registered one-hot grant and bounded tenure.
// Optional round-robin priority rotation: define ARB_ROUND_ROBIN_EN.
module req_arbiter_4_v
  import req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_id,
  output logic               o_valid,
  output logic               o_timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] enc_in;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               owner_req;

  assign elig      = i_req & ~mask_q;
  assign owner_req = i_req[gnt_id_q];

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Rotate so the pointer line lands at bit 0, encode, then rotate the index back.
  always_comb begin
    enc_in = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      enc_in[k] = elig[IDX_W'(k) + ptr_q];
    end
  end

  assign win_idx = enc_idx + ptr_q;
`else
  assign enc_in  = elig;
  assign win_idx = enc_idx;
`endif

  priority_enc_4_2_v u_enc (
    .i_req   (enc_in),
    .o_idx   (enc_idx),
    .o_valid (enc_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        valid_d  = 1'b0;
        if (enc_valid) begin
          state_d  = GRANT;
          gnt_d    = onehot_from_idx(win_idx);
          gnt_id_d = win_idx;
          valid_d  = 1'b1;
          cnt_d    = '0;
          mask_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d    = win_idx + IDX_W'(1);
`endif
        end else if (|i_req) begin
          // Only masked lines are asking: unmask so they win next cycle.
          mask_d = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!owner_req || cnt_q == HOLD_LAST) begin
          state_d  = IDLE;
          gnt_d    = '0;
          gnt_id_d = '0;
          valid_d  = 1'b0;
          if (owner_req) begin
            timeout_d = 1'b1;
            mask_d    = mask_q | onehot_from_idx(gnt_id_q);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      mask_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_id  = gnt_id_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_req_arbiter_4_v.sv
// Directed-vector bench for req_arbiter_4_v (MAX_HOLD=16).
module tb_req_arbiter_4_v;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_req;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_id;
  logic       o_valid;
  logic       o_timeout;

  int unsigned n_checks;
  int unsigned n_errors;

  req_arbiter_4_v #(
    .MAX_HOLD (16),
    .CNT_W    (5)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req),
    .o_gnt     (o_gnt),
    .o_gnt_id  (o_gnt_id),
    .o_valid   (o_valid),
    .o_timeout (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] gnt, input logic [1:0] id,
                            input logic tmo);
    check({tag, ".gnt"}, 32'(o_gnt), 32'(gnt));
    check({tag, ".id"}, 32'(o_gnt_id), 32'(id));
    check({tag, ".valid"}, 32'(o_valid), 32'(gnt != 4'b0000));
    check({tag, ".tmo"}, 32'(o_timeout), 32'(tmo));
  endtask

  // Expects gnt already showing on the current sample; checks it holds 16 cycles total.
  task automatic expect_tenure(input string tag, input logic [3:0] gnt, input logic [1:0] id);
    for (int k = 0; k < 16; k++) begin
      check({tag, ".hold"}, 32'(o_gnt), 32'(gnt));
      check({tag, ".holdid"}, 32'(o_gnt_id), 32'(id));
      if (k < 15) step();
    end
    step();
    expect_out({tag, ".expire"}, 4'b0000, 2'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    i_rst_n  = 1'b0;
    i_req    = 4'b1111;
    repeat (3) @(negedge i_clk);
    expect_out("reset", 4'b0000, 2'd0, 1'b0);

    // Release reset with all lines requesting: line 0 wins one cycle later.
    i_rst_n = 1'b1;
    step();
    expect_out("first", 4'b0001, 2'd0, 1'b0);
    i_req = 4'b0000;
    step();
    expect_out("rel0", 4'b0000, 2'd0, 1'b0);

    // 1010: line 1 first, then line 3 after one idle cycle.
    i_req = 4'b1010;
    step();
    expect_out("g1", 4'b0010, 2'd1, 1'b0);
    i_req = 4'b1000;
    step();
    expect_out("turn", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("g3", 4'b1000, 2'd3, 1'b0);
    i_req = 4'b0000;
    step();
    expect_out("rel3", 4'b0000, 2'd0, 1'b0);

    // Single requester held forever: 16-cycle tenure, timeout, unmask, regrant.
    i_req = 4'b0100;
    step();
    expect_tenure("solo", 4'b0100, 2'd2);
    step();
    expect_out("unmask", 4'b0000, 2'd0, 1'b0);
    step();
    expect_out("regrant", 4'b0100, 2'd2, 1'b0);
    i_req = 4'b0000;
    step();
    expect_out("rel2", 4'b0000, 2'd0, 1'b0);

    // 0011 held: line 0 times out, masked line 0 lets line 1 in, then back to 0.
    i_req = 4'b0011;
    step();
    expect_tenure("pair0", 4'b0001, 2'd0);
    step();
    check("pair1.first.tmo", 32'(o_timeout), 32'(1'b0));
    expect_tenure("pair1", 4'b0010, 2'd1);
    step();
    expect_out("pair0b", 4'b0001, 2'd0, 1'b0);
    i_req = 4'b0000;
    step();
    expect_out("relp", 4'b0000, 2'd0, 1'b0);

    // Release and expiry coincide: release wins, no timeout.
    i_req = 4'b1000;
    step();
    for (int k = 0; k < 15; k++) step();
    check("coin.hold", 32'(o_gnt), 32'(4'b1000));
    i_req = 4'b0000;
    step();
    expect_out("coin.rel", 4'b0000, 2'd0, 1'b0);

    // Single-cycle pulse in IDLE still wins a one-cycle grant.
    i_req = 4'b0100;
    @(posedge i_clk);
    #1 i_req = 4'b0000;
    @(negedge i_clk);
    expect_out("pulse", 4'b0100, 2'd2, 1'b0);
    step();
    expect_out("pulse.rel", 4'b0000, 2'd0, 1'b0);

    // Asynchronous reset mid-tenure (counter = 7), then a fresh full tenure.
    i_req = 4'b0100;
    step();
    for (int k = 0; k < 7; k++) step();
    check("mid.hold", 32'(o_gnt), 32'(4'b0100));
    #2 i_rst_n = 1'b0;
    #1;
    expect_out("mid.rst", 4'b0000, 2'd0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    expect_tenure("post", 4'b0100, 2'd2);
    i_req = 4'b0000;
    step();
    step();
    expect_out("idle_end", 4'b0000, 2'd0, 1'b0);

`ifdef ARB_ROUND_ROBIN_EN
    // Round robin: every owner releases after two cycles; order 0,1,2,3,0.
    begin
      logic [1:0] exp_id;
      logic [3:0] oh;
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_req   = 4'b1111;
      exp_id  = 2'd0;
      step();
      for (int n = 0; n < 5; n++) begin
        oh = 4'b0001 << exp_id;
        expect_out("rr.g", oh, exp_id, 1'b0);
        step();
        check("rr.hold", 32'(o_gnt), 32'(oh));
        i_req = 4'b1111 & ~oh;
        step();
        expect_out("rr.rel", 4'b0000, 2'd0, 1'b0);
        i_req = 4'b1111;
        step();
        exp_id = exp_id + 2'd1;
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
